// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Used by quad_glitch_filter and quad_step_decoder.
package quad_pkg;

  // Decoder FSM: INIT aligns to the power-up position, RUN decodes steps.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // {A,B} phases, listed in up-count order.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Direction levels, matching the counter's mode input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int ERR_CNT_W = 8;

  // True when prev->cur is one single-bit step in the up order.
  function automatic logic is_up_step(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      {PH_00, PH_10},
      {PH_10, PH_11},
      {PH_11, PH_01},
      {PH_01, PH_00}: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One quadrature channel: synchroniser chain, persistence filter and
// a stable flag used to leave power-up alignment.
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic track,
  output logic filt,
  output logic stable
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r, cnt_next_s;
  logic [CNT_W-1:0]       quiet_r, quiet_next_s;
  logic                   filt_r, filt_next_s;
  logic                   stable_r;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign filt   = filt_r;
  assign stable = stable_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Filter decision: follow directly while tracking, otherwise require
  // the new level to persist until the counter reaches FILT_LEN.
  always_comb begin
    cnt_next_s  = cnt_r;
    filt_next_s = filt_r;
    if (track) begin
      filt_next_s = sync_s;
      cnt_next_s  = CNT_ZERO;
    end else if (sync_s == filt_r) begin
      cnt_next_s  = CNT_ZERO;
    end else if (cnt_r == FILT_MAX) begin
      filt_next_s = sync_s;
      cnt_next_s  = CNT_ZERO;
    end else begin
      cnt_next_s  = cnt_r + CNT_ONE;
    end
  end

  // Quiet-time counter: any pending or tracked change restarts it.
  always_comb begin
    quiet_next_s = quiet_r;
    if ((cnt_next_s != CNT_ZERO) || (sync_s != filt_r)) begin
      quiet_next_s = CNT_ZERO;
    end else if (quiet_r != FILT_MAX) begin
      quiet_next_s = quiet_r + CNT_ONE;
    end else begin
      quiet_next_s = quiet_r;
    end
  end

  // Register filter state and the stable flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= CNT_ZERO;
      quiet_r  <= CNT_ZERO;
      filt_r   <= 1'b0;
      stable_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_next_s;
      quiet_r  <= quiet_next_s;
      filt_r   <= filt_next_s;
      stable_r <= (quiet_next_s == FILT_MAX);
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front-end: produces a one-cycle step strobe, a direction
// level and an illegal-transition pulse from two asynchronous channels.
// Optional macro QUAD_ERR_CNT_EN adds a saturating illegal-transition count.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_in,
  input  logic                 b_in,
  output logic                 step,
  output logic                 mode,
  output logic                 err,
  output logic [1:0]           ab_state,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t     state_r, state_next_s;
  logic       track_s;
  logic       filt_a_s, filt_b_s, stable_a_s, stable_b_s;
  logic [1:0] ab_s, prev_ab_r, change_s;
  logic       step_r, step_next_s;
  logic       err_r, err_next_s;
  logic       mode_r, mode_next_s;

  assign track_s  = (state_r == ST_INIT);
  assign ab_s     = {filt_a_s, filt_b_s};
  assign change_s = ab_s ^ prev_ab_r;

  assign ab_state = ab_s;
  assign step     = step_r;
  assign err      = err_r;
  assign mode     = mode_r;

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk    (clk),
    .reset  (reset),
    .din    (a_in),
    .track  (track_s),
    .filt   (filt_a_s),
    .stable (stable_a_s)
  );

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk    (clk),
    .reset  (reset),
    .din    (b_in),
    .track  (track_s),
    .filt   (filt_b_s),
    .stable (stable_b_s)
  );

  // Next state and decoded step/err/mode from the previous vs current phase.
  always_comb begin
    state_next_s = state_r;
    step_next_s  = 1'b0;
    err_next_s   = 1'b0;
    mode_next_s  = mode_r;
    case (state_r)
      ST_INIT: begin
        if (stable_a_s && stable_b_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (change_s == 2'b11) begin
          err_next_s  = 1'b1;
        end else if (change_s != 2'b00) begin
          step_next_s = 1'b1;
          mode_next_s = is_up_step(prev_ab_r, ab_s) ? DIR_UP : DIR_DN;
        end else begin
          step_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // State, previous phase and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_INIT;
      prev_ab_r <= PH_00;
      step_r    <= 1'b0;
      err_r     <= 1'b0;
      mode_r    <= DIR_UP;
    end else begin
      state_r   <= state_next_s;
      prev_ab_r <= ab_s;
      step_r    <= step_next_s;
      err_r     <= err_next_s;
      mode_r    <= mode_next_s;
    end
  end

`ifdef QUAD_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Count illegal transitions, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (err_next_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: every driven edge pushes its
// expected step/err event with its due cycle; the per-cycle monitor pops
// and compares, and checks that nothing fires in between.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_in, b_in;
  logic       step, mode, err;
  logic [1:0] ab_state;
  logic [7:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int errs        = 0;

  logic [1:0] model_ab;
  logic       model_mode;

  typedef struct {
    int   due;
    logic st;
    logic er;
    logic md;
  } ev_t;
  ev_t q[$];

  quad_step_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .step     (step),
    .mode     (mode),
    .err      (err),
    .ab_state (ab_state),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ph_idx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] exp_err_cnt();
`ifdef QUAD_ERR_CNT_EN
    if (errs > 255) return 8'hFF;
    return 8'(errs);
`else
    return 8'h00;
`endif
  endfunction

  // Advance one clock (to the falling edge) and run the monitor.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check_eq("step", {31'd0, step}, {31'd0, e.st});
      check_eq("err", {31'd0, err}, {31'd0, e.er});
      check_eq("mode", {31'd0, mode}, {31'd0, e.md});
    end else begin
      check_eq("quiet", {30'd0, step, err}, 32'd0);
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive a new {A,B} and predict the event 8 falling edges later
  // (first sample + SYNC_STAGES + FILT_LEN + 1 rising edges).
  task automatic move(input logic a, input logic b);
    logic [1:0] nxt;
    ev_t        e;
    nxt = {a, b};
    e.due = cyc + 8;
    e.st  = 1'b0;
    e.er  = 1'b0;
    if ((nxt ^ model_ab) == 2'b11) begin
      e.er = 1'b1;
      errs++;
    end else if (nxt != model_ab) begin
      e.st = 1'b1;
      model_mode = (ph_idx(nxt) == ((ph_idx(model_ab) + 1) % 4));
    end
    e.md = model_mode;
    if (e.st || e.er) q.push_back(e);
    model_ab = nxt;
    a_in = a;
    b_in = b;
  endtask

  initial begin
    // Reset with both channels high.
    reset = 1'b1; a_in = 1'b1; b_in = 1'b1;
    model_ab = 2'b11; model_mode = 1'b1;
    hold(5);
    check_eq("rst_mode", {31'd0, mode}, 32'd1);
    check_eq("rst_ab", {30'd0, ab_state}, 32'd0);
    check_eq("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    hold(20);
    check_eq("init_ab", {30'd0, ab_state}, 32'd3);

    // Walk to 00 then a full up cycle.
    move(1'b0, 1'b1); hold(20);
    move(1'b0, 1'b0); hold(20);
    move(1'b1, 1'b0); hold(20);
    move(1'b1, 1'b1); hold(20);
    move(1'b0, 1'b1); hold(20);
    move(1'b0, 1'b0); hold(20);
    check_eq("up_ab", {30'd0, ab_state}, 32'd0);

    // Full down cycle.
    move(1'b0, 1'b1); hold(20);
    move(1'b1, 1'b1); hold(20);
    move(1'b1, 1'b0); hold(20);
    move(1'b0, 1'b0); hold(20);
    check_eq("dn_mode", {31'd0, mode}, 32'd0);

    // Reversal mid-sequence: down, down, up, up.
    move(1'b0, 1'b1); hold(20);
    move(1'b1, 1'b1); hold(20);
    move(1'b0, 1'b1); hold(20);
    move(1'b0, 1'b0); hold(20);
    move(1'b0, 1'b1); hold(20);

    // 3-cycle glitch on A is discarded.
    a_in = 1'b1; hold(3);
    a_in = 1'b0; hold(20);
    check_eq("glitch_ab", {30'd0, ab_state}, 32'd1);

    // Back to 00 leaving mode=0, then an illegal 00->11.
    move(1'b0, 1'b0); hold(20);
    move(1'b1, 1'b0); hold(20);
    move(1'b0, 1'b0); hold(20);
    move(1'b1, 1'b1); hold(20);
    check_eq("err_ab", {30'd0, ab_state}, 32'd3);
    check_eq("errcnt_1", {24'd0, err_cnt}, {24'd0, exp_err_cnt()});

    // 300 further illegal transitions saturate the counter.
    for (int i = 0; i < 300; i++) begin
      move(~model_ab[1], ~model_ab[0]);
      hold(8);
    end
    hold(12);
    check_eq("errcnt_sat", {24'd0, err_cnt}, {24'd0, exp_err_cnt()});
    check_eq("err_mode", {31'd0, mode}, 32'd0);

    // Reset two cycles after an edge is sampled: the edge never steps.
    a_in = 1'b0;
    hold(2);
    reset = 1'b1;
    #1;
    check_eq("mid_step", {31'd0, step}, 32'd0);
    check_eq("mid_err", {31'd0, err}, 32'd0);
    check_eq("mid_mode", {31'd0, mode}, 32'd1);
    check_eq("mid_ab", {30'd0, ab_state}, 32'd0);
    check_eq("mid_errcnt", {24'd0, err_cnt}, 32'd0);
    hold(3);
    reset = 1'b0;
    model_ab = 2'b01; model_mode = 1'b1; errs = 0;
    hold(25);
    check_eq("post_ab", {30'd0, ab_state}, 32'd1);
    check_eq("post_errcnt", {24'd0, err_cnt}, 32'd0);

    // Normal decoding resumes: 01->11 is a down step.
    move(1'b1, 1'b1); hold(20);
    check_eq("post_mode", {31'd0, mode}, 32'd0);
    check_eq("pending", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
